// File: rtl/encoder_pkg.sv
// encoder_pkg: shared state encoding and default sizing for the encoder sequencer
package encoder_pkg;
  localparam int LINES_DEF = 64;
  localparam int IDX_W_DEF = 6;
  localparam int TIMEOUT_DEF = 1024;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_LOAD_TAIL = 3'd2;
  localparam logic [2:0] S_CALC = 3'd3;
  localparam logic [2:0] S_STORE = 3'd4;
  localparam logic [2:0] S_FIN = 3'd5;
  typedef enum logic [2:0] {
    IDLE = S_IDLE,
    LOAD = S_LOAD,
    LOAD_TAIL = S_LOAD_TAIL,
    CALC = S_CALC,
    STORE = S_STORE,
    FIN = S_FIN
  } state_t;
endpackage

// File: rtl/encoder_sequencer_slice_counter.sv
// slice_counter: slice index down-counter with load to LINES-1 and terminal count at zero
module slice_counter #(
  parameter int LINES = 64,
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  output logic [IDX_W-1:0] q,
  output logic             co
);
  localparam logic [IDX_W-1:0] TOP = IDX_W'(LINES - 1);
  // load has priority over decrement; reset parks the index at the top slice
  always_ff @(posedge clk)
    if (!rst) q <= TOP;
    else if (load) q <= TOP;
    else if (en) q <= q - 1'b1;
  assign co = q == '0;
endmodule

// File: rtl/encoder_sequencer.sv
// encoder_sequencer: sequences load, compute and store of one 64-slice encoder pass
module encoder_sequencer
  import encoder_pkg::*;
#(
  parameter int LINES = LINES_DEF,
  parameter int IDX_W = IDX_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             calc_done,
  output logic [IDX_W-1:0] slice_idx,
  output logic             rd_en,
  output logic             ld_en,
  output logic             calc_start,
  output logic             mux_sel,
  output logic             wr_en,
  output logic             busy,
  output logic             done,
  output logic             error
);
  localparam int TO_W = $clog2(TIMEOUT + 1);
  state_t state, nxt;
  logic [TO_W-1:0] to_cnt;
  logic co, accept, timeout, cnt_en, cnt_load;
  assign accept = state == IDLE && start;
  assign timeout = state == CALC && !calc_done && to_cnt == TO_W'(TIMEOUT - 1);
  assign cnt_en = state == LOAD || state == STORE;
  assign cnt_load = accept || (cnt_en && co);
  slice_counter #(.LINES(LINES), .IDX_W(IDX_W)) u_slice (
    .clk(clk),
    .rst(rst),
    .load(cnt_load),
    .en(cnt_en),
    .q(slice_idx),
    .co(co)
  );
  // next-state: each phase advances on its terminal condition
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = start ? LOAD : IDLE;
      LOAD: nxt = co ? LOAD_TAIL : LOAD;
      LOAD_TAIL: nxt = CALC;
      CALC: nxt = calc_done ? STORE : timeout ? IDLE : CALC;
      STORE: nxt = co ? FIN : STORE;
      FIN: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk)
    if (!rst) state <= IDLE;
    else state <= nxt;
  // CALC cycle counter, cleared whenever the FSM is outside CALC
  always_ff @(posedge clk)
    if (!rst) to_cnt <= '0;
    else to_cnt <= state == CALC ? to_cnt + 1'b1 : '0;
  // registered outputs decoded from the upcoming state so they align with it
  always_ff @(posedge clk)
    if (!rst) begin
      rd_en <= 1'b0;
      ld_en <= 1'b0;
      calc_start <= 1'b0;
      mux_sel <= 1'b0;
      wr_en <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
    end else begin
      rd_en <= nxt == LOAD;
      ld_en <= rd_en;
      calc_start <= state == LOAD_TAIL;
      mux_sel <= nxt == STORE;
      wr_en <= nxt == STORE;
      busy <= nxt != IDLE;
      done <= nxt == FIN;
      error <= accept ? 1'b0 : timeout ? 1'b1 : error;
    end
endmodule

// File: tb/tb_encoder_sequencer.sv
// tb_encoder_sequencer: randomized directed passes checked against a cycle-indexed pass model
module tb_encoder_sequencer;
  localparam int L = 64;
  localparam int TO = 16;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic calc_done = 1'b0;
  logic [5:0] slice_idx;
  logic rd_en, ld_en, calc_start, mux_sel, wr_en, busy, done, error;
  logic [13:0] obs;
  int tests = 0;
  int fails = 0;
  int n_busy, n_done, n_wr, c;
  encoder_sequencer #(.LINES(L), .IDX_W(6), .TIMEOUT(TO)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .calc_done(calc_done),
    .slice_idx(slice_idx),
    .rd_en(rd_en),
    .ld_en(ld_en),
    .calc_start(calc_start),
    .mux_sel(mux_sel),
    .wr_en(wr_en),
    .busy(busy),
    .done(done),
    .error(error)
  );
  always #5 clk = ~clk;
  assign obs = {busy, done, error, rd_en, ld_en, calc_start, mux_sel, wr_en, slice_idx};
  function automatic logic [13:0] model(int k, int cc, bit tmo);
    int idx = L - 1;
    int st0 = L + 2 + cc;
    int fin = 2 * L + 2 + cc;
    bit b, d, e, rd, ld, cs, ms, wr;
    rd = k <= L;
    if (rd) idx = L - k;
    ld = k >= 2 && k <= L + 1;
    cs = k == L + 2;
    b = tmo ? k <= L + 1 + cc : k <= fin;
    e = tmo && k > L + 1 + cc;
    ms = !tmo && k >= st0 && k < fin;
    wr = ms;
    if (ms) idx = L - 1 - (k - st0);
    d = !tmo && k == fin;
    return {b, d, e, rd, ld, cs, ms, wr, 6'(idx)};
  endfunction
  task automatic chk(string tag, logic [31:0] o, logic [31:0] x);
    tests++;
    assert (o === x) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, o, x);
    end
  endtask
  task automatic run_pass(int cc, bit tmo, bit spur, bit chain, int abort_k);
    int kend = tmo ? L + 2 + cc : 2 * L + 3 + cc;
    bit in_calc;
    n_busy = 0;
    n_done = 0;
    n_wr = 0;
    for (int k = 1; k <= kend; k++) begin
      @(posedge clk);
      #1;
      if (abort_k != 0 && k == abort_k) return;
      chk($sformatf("pass_c%0d_k%0d", cc, k), 32'(obs), 32'(model(k, cc, tmo)));
      n_busy += int'(busy);
      n_done += int'(done);
      n_wr += int'(wr_en);
      in_calc = k >= L + 2 && k <= L + 1 + cc;
      start = k == kend ? chain : spur ? 1'($urandom_range(1)) : 1'b0;
      calc_done = in_calc ? (!tmo && k == L + 1 + cc) : (spur ? 1'($urandom_range(1)) : 1'b0);
    end
  endtask
  task automatic kick();
    @(posedge clk);
    #1;
    start = 1'b1;
    calc_done = 1'b0;
  endtask
  initial begin
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_init", 32'(obs), 32'h3f);
    rst = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_after_reset", 32'(obs), 32'h3f);
    kick();
    run_pass(10, 0, 0, 0, 0);
    chk("normal_len", n_busy + 1, 141);
    chk("normal_done", n_done, 1);
    chk("normal_wr", n_wr, L);
    kick();
    run_pass(1, 0, 0, 0, 0);
    chk("immediate_len", n_busy + 1, 132);
    chk("immediate_done", n_done, 1);
    c = $urandom_range(2, TO - 1);
    kick();
    run_pass(c, 0, 1, 0, 0);
    chk("spurious_done", n_done, 1);
    chk("spurious_len", n_busy + 1, 2 * L + 3 + c);
    kick();
    run_pass(TO, 1, 1, 0, 0);
    chk("timeout_done", n_done, 0);
    chk("timeout_wr", n_wr, 0);
    chk("timeout_error", 32'(error), 1);
    c = $urandom_range(1, TO - 1);
    kick();
    run_pass(c, 0, 0, 1, 0);
    chk("b2b_first_done", n_done, 1);
    run_pass(c, 0, 0, 0, 0);
    chk("b2b_second_done", n_done, 1);
    chk("b2b_second_len", n_busy + 1, 2 * L + 3 + c);
    for (int i = 0; i < 4; i++) begin
      c = $urandom_range(1, TO - 1);
      kick();
      run_pass(c, 0, 1, 0, 0);
      chk($sformatf("rand%0d_done", i), n_done, 1);
    end
    kick();
    run_pass(5, 0, 0, 0, L + 2 + 5 + 20);
    start = 1'b0;
    calc_done = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("reset_mid_store%0d", i), 32'(obs), 32'h3f);
    end
    rst = 1'b1;
    n_wr = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      n_wr += int'(wr_en);
      chk($sformatf("post_reset_idle%0d", i), 32'(obs), 32'h3f);
    end
    chk("post_reset_wr", n_wr, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
